gat_load_sequencer: RTL and testbench

//  Host-side controller in front of the GAT top-level block. Takes one 32-bit word stream
//  and routes it into the BRAM write ports in a fixed order: H data, H node info, weight, subgraph.

---
 rtl/gat_load_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_gat_load_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gat_load_sequencer.sv
// Loads the GAT BRAM regions from one word stream, then streams the feature BRAM back out.
// Optional WAIT_GAT watchdog: define GAT_LOAD_TIMEOUT_EN.
module gat_load_sequencer #(
    parameter int TOP_WIDTH          = 32,
    parameter int H_DATA_DEPTH       = 242101,
    parameter int NODE_INFO_DEPTH    = 13264,
    parameter int WEIGHT_DEPTH       = 22928,
    parameter int SUBGRAPH_DEPTH     = 13264,
    parameter int FEAT_WORDS         = 43328,
`ifdef GAT_LOAD_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES     = 2**24,
`endif
    parameter int H_DATA_ADDR_W      = $clog2(H_DATA_DEPTH),
    parameter int H_NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH),
    parameter int WGT_ADDR_W         = $clog2(WEIGHT_DEPTH),
    parameter int SUBGRAPH_ADDR_W    = $clog2(SUBGRAPH_DEPTH),
    parameter int NEW_FEATURE_ADDR_W = $clog2(FEAT_WORDS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [TOP_WIDTH-1:0]            s_data,
    input  logic                            s_valid,
    input  logic                            s_last,
    output logic                            s_ready,
    output logic [TOP_WIDTH-1:0]            h_data_bram_din,
    output logic                            h_data_bram_ena,
    output logic                            h_data_bram_wea,
    output logic [H_DATA_ADDR_W+1:0]        h_data_bram_addra,
    output logic [TOP_WIDTH-1:0]            h_node_info_bram_din,
    output logic                            h_node_info_bram_ena,
    output logic                            h_node_info_bram_wea,
    output logic [H_NODE_INFO_ADDR_W+1:0]   h_node_info_bram_addra,
    output logic [TOP_WIDTH-1:0]            wgt_bram_din,
    output logic                            wgt_bram_ena,
    output logic                            wgt_bram_wea,
    output logic [WGT_ADDR_W+1:0]           wgt_bram_addra,
    output logic [TOP_WIDTH-1:0]            subgraph_bram_din,
    output logic                            subgraph_bram_ena,
    output logic                            subgraph_bram_wea,
    output logic [SUBGRAPH_ADDR_W+1:0]      subgraph_bram_addra,
    output logic                            h_data_bram_load_done,
    output logic                            h_node_info_bram_load_done,
    output logic                            wgt_bram_load_done,
    input  logic                            gat_ready,
    output logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb,
    input  logic [TOP_WIDTH-1:0]            feat_bram_dout,
    output logic [TOP_WIDTH-1:0]            m_data,
    output logic                            m_valid,
    output logic                            m_last,
    input  logic                            m_ready,
    output logic                            busy,
    output logic                            err
);

    localparam int MAX_AB    = (H_DATA_DEPTH > NODE_INFO_DEPTH) ? H_DATA_DEPTH : NODE_INFO_DEPTH;
    localparam int MAX_CD    = (WEIGHT_DEPTH > SUBGRAPH_DEPTH) ? WEIGHT_DEPTH : SUBGRAPH_DEPTH;
    localparam int MAX_DEPTH = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int IDX_W     = $clog2(MAX_DEPTH + 1);
    localparam int RD_W      = $clog2(FEAT_WORDS + 1);
`ifdef GAT_LOAD_TIMEOUT_EN
    localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
`endif

    typedef enum logic [2:0] {IDLE, LD_H, LD_NI, LD_W, LD_SG, WAIT_GAT, DRAIN} state_t;

    state_t               state;
    logic [IDX_W-1:0]     word_idx;
    logic [IDX_W-1:0]     lim;
    logic                 beat;
    logic                 wr_ok;
    logic [RD_W-1:0]      rd_idx;
    logic                 issue;
    logic                 pop;
    logic [2:0]           occ;
    logic                 rd_vld_p1;
    logic                 rd_last_p1;
    logic [TOP_WIDTH-1:0] fifo_data [2];
    logic [1:0]           fifo_last;
    logic [1:0]           fifo_cnt;
    logic                 wr_ptr;
    logic                 rd_ptr;
`ifdef GAT_LOAD_TIMEOUT_EN
    logic [TMO_W-1:0]     tmo_cnt;
`endif

    always_comb begin
        lim = '0;
        case (state)
            LD_H:    lim = IDX_W'(H_DATA_DEPTH);
            LD_NI:   lim = IDX_W'(NODE_INFO_DEPTH);
            LD_W:    lim = IDX_W'(WEIGHT_DEPTH);
            LD_SG:   lim = IDX_W'(SUBGRAPH_DEPTH);
            default: lim = '0;
        endcase
    end

    assign s_ready = (state == LD_H) || (state == LD_NI) || (state == LD_W) || (state == LD_SG);
    assign beat    = s_valid && s_ready;
    // A beat landing past the region's depth is swallowed without a write.
    assign wr_ok   = beat && (word_idx != lim);
    assign busy    = (state != IDLE);

    assign h_data_bram_ena        = wr_ok && (state == LD_H);
    assign h_data_bram_wea        = h_data_bram_ena;
    assign h_data_bram_din        = h_data_bram_ena ? s_data : '0;
    assign h_data_bram_addra      = h_data_bram_ena ? {word_idx[H_DATA_ADDR_W-1:0], 2'b00} : '0;
    assign h_node_info_bram_ena   = wr_ok && (state == LD_NI);
    assign h_node_info_bram_wea   = h_node_info_bram_ena;
    assign h_node_info_bram_din   = h_node_info_bram_ena ? s_data : '0;
    assign h_node_info_bram_addra = h_node_info_bram_ena ? {word_idx[H_NODE_INFO_ADDR_W-1:0], 2'b00} : '0;
    assign wgt_bram_ena           = wr_ok && (state == LD_W);
    assign wgt_bram_wea           = wgt_bram_ena;
    assign wgt_bram_din           = wgt_bram_ena ? s_data : '0;
    assign wgt_bram_addra         = wgt_bram_ena ? {word_idx[WGT_ADDR_W-1:0], 2'b00} : '0;
    assign subgraph_bram_ena      = wr_ok && (state == LD_SG);
    assign subgraph_bram_wea      = subgraph_bram_ena;
    assign subgraph_bram_din      = subgraph_bram_ena ? s_data : '0;
    assign subgraph_bram_addra    = subgraph_bram_ena ? {word_idx[SUBGRAPH_ADDR_W-1:0], 2'b00} : '0;

    // Stage p0: issue feature read; the pop this cycle frees a slot so the stream sustains 1 word/cycle.
    assign m_valid = (fifo_cnt != 2'd0);
    assign m_data  = m_valid ? fifo_data[rd_ptr] : '0;
    assign m_last  = m_valid && fifo_last[rd_ptr];
    assign pop     = m_valid && m_ready;
    assign occ     = 3'(fifo_cnt) + 3'(rd_vld_p1) - 3'(pop);
    assign issue   = (state == DRAIN) && (rd_idx < RD_W'(FEAT_WORDS)) && (occ < 3'd2);
    assign feat_bram_addrb = (state == DRAIN) ? {rd_idx[NEW_FEATURE_ADDR_W-1:0], 2'b00} : '0;

    // Stage p1: BRAM read data arrives and is written into the output FIFO.
    always_ff @(posedge clk) begin
        if (rd_vld_p1) fifo_data[wr_ptr] <= feat_bram_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                      <= IDLE;
            word_idx                   <= '0;
            rd_idx                     <= '0;
            rd_vld_p1                  <= 1'b0;
            rd_last_p1                 <= 1'b0;
            fifo_last                  <= '0;
            fifo_cnt                   <= '0;
            wr_ptr                     <= 1'b0;
            rd_ptr                     <= 1'b0;
            h_data_bram_load_done      <= 1'b0;
            h_node_info_bram_load_done <= 1'b0;
            wgt_bram_load_done         <= 1'b0;
            err                        <= 1'b0;
`ifdef GAT_LOAD_TIMEOUT_EN
            tmo_cnt                    <= '0;
`endif
        end else begin
            rd_vld_p1  <= issue;
            rd_last_p1 <= issue && (rd_idx == RD_W'(FEAT_WORDS - 1));
            if (issue) rd_idx <= rd_idx + 1'b1;
            if (rd_vld_p1) begin
                fifo_last[wr_ptr] <= rd_last_p1;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + 2'(rd_vld_p1) - 2'(pop);

            case (state)
                IDLE: begin
                    if (start) begin
                        h_data_bram_load_done      <= 1'b0;
                        h_node_info_bram_load_done <= 1'b0;
                        wgt_bram_load_done         <= 1'b0;
                        err                        <= 1'b0;
                        word_idx                   <= '0;
                        rd_idx                     <= '0;
                        state                      <= LD_H;
                    end
                end
                LD_H, LD_NI, LD_W, LD_SG: begin
                    if (beat) begin
                        if (word_idx == lim) err <= 1'b1;
                        else word_idx <= word_idx + 1'b1;
                        if (s_last) begin
                            word_idx <= '0;
                            state    <= state_t'(state + 3'd1);
                            if (state == LD_H)  h_data_bram_load_done      <= 1'b1;
                            if (state == LD_NI) h_node_info_bram_load_done <= 1'b1;
                            if (state == LD_W)  wgt_bram_load_done         <= 1'b1;
`ifdef GAT_LOAD_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end
                    end
                end
                WAIT_GAT: begin
                    if (gat_ready) begin
                        state <= DRAIN;
`ifdef GAT_LOAD_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        rd_idx <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gat_load_sequencer.sv
// Directed, table-driven bench for gat_load_sequencer (small weight depth and feature count).
module tb_gat_load_sequencer;

    localparam int FW = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic [31:0] h_data_bram_din, h_node_info_bram_din, wgt_bram_din, subgraph_bram_din;
    logic        h_data_bram_ena, h_data_bram_wea, h_node_info_bram_ena, h_node_info_bram_wea;
    logic        wgt_bram_ena, wgt_bram_wea, subgraph_bram_ena, subgraph_bram_wea;
    logic [19:0] h_data_bram_addra;
    logic [15:0] h_node_info_bram_addra;
    logic [3:0]  wgt_bram_addra;
    logic [15:0] subgraph_bram_addra;
    logic        h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done;
    logic        gat_ready = 1'b0;
    logic [7:0]  feat_bram_addrb;
    logic [31:0] feat_bram_dout = '0;
    logic [31:0] m_data;
    logic        m_valid, m_last;
    logic        m_ready = 1'b0;
    logic        busy, err;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    gat_load_sequencer #(
        .WEIGHT_DEPTH(4),
`ifdef GAT_LOAD_TIMEOUT_EN
        .TIMEOUT_CYCLES(100),
`endif
        .FEAT_WORDS(FW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .h_data_bram_din(h_data_bram_din), .h_data_bram_ena(h_data_bram_ena),
        .h_data_bram_wea(h_data_bram_wea), .h_data_bram_addra(h_data_bram_addra),
        .h_node_info_bram_din(h_node_info_bram_din), .h_node_info_bram_ena(h_node_info_bram_ena),
        .h_node_info_bram_wea(h_node_info_bram_wea), .h_node_info_bram_addra(h_node_info_bram_addra),
        .wgt_bram_din(wgt_bram_din), .wgt_bram_ena(wgt_bram_ena),
        .wgt_bram_wea(wgt_bram_wea), .wgt_bram_addra(wgt_bram_addra),
        .subgraph_bram_din(subgraph_bram_din), .subgraph_bram_ena(subgraph_bram_ena),
        .subgraph_bram_wea(subgraph_bram_wea), .subgraph_bram_addra(subgraph_bram_addra),
        .h_data_bram_load_done(h_data_bram_load_done),
        .h_node_info_bram_load_done(h_node_info_bram_load_done),
        .wgt_bram_load_done(wgt_bram_load_done),
        .gat_ready(gat_ready), .feat_bram_addrb(feat_bram_addrb), .feat_bram_dout(feat_bram_dout),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .err(err)
    );

    // Feature BRAM model: word k holds FEA70000+k, one cycle read latency.
    always_ff @(posedge clk) feat_bram_dout <= 32'hFEA7_0000 + 32'(feat_bram_addrb[7:2]);

    typedef struct {
        int          region;
        logic [31:0] data;
        logic        last;
        logic [3:0]  ena;
        logic [19:0] addr;
        logic [2:0]  done;
        logic        errx;
    } beat_t;

    beat_t tbl [22];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_beat(input int i, input int r, input logic l, input logic [3:0] e,
                            input logic [19:0] a, input logic [2:0] d, input logic x);
        tbl[i] = '{r, 32'hD000_0000 + 32'(i) * 32'h0101_0101, l, e, a, d, x};
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_beats(input int lo, input int hi);
        logic [19:0] a;
        logic [31:0] d;
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = tbl[i].data; s_last = tbl[i].last;
            #1;
            case (tbl[i].region)
                0: begin a = h_data_bram_addra;          d = h_data_bram_din;      end
                1: begin a = 20'(h_node_info_bram_addra); d = h_node_info_bram_din; end
                2: begin a = 20'(wgt_bram_addra);         d = wgt_bram_din;         end
                default: begin a = 20'(subgraph_bram_addra); d = subgraph_bram_din; end
            endcase
            chk("s_ready", s_ready, 1);
            chk("ena", {subgraph_bram_ena, wgt_bram_ena, h_node_info_bram_ena, h_data_bram_ena}, tbl[i].ena);
            chk("wea", {subgraph_bram_wea, wgt_bram_wea, h_node_info_bram_wea, h_data_bram_wea}, tbl[i].ena);
            chk("addra", a, (tbl[i].ena != 0) ? tbl[i].addr : 20'd0);
            chk("din", d, (tbl[i].ena != 0) ? tbl[i].data : 32'd0);
            @(posedge clk); #1;
            chk("load_done", {wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done}, tbl[i].done);
            chk("err", err, tbl[i].errx);
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    // mode 0: m_ready always 1; mode 1: m_ready pattern 1,0,0,1.
    task automatic drain(input int mode);
        int k = 0, cyc = 0;
        logic held = 1'b0;
        logic [31:0] hd = '0;
        logic mr;
        logic [3:0] pat = 4'b1001;
        while (k < FW && cyc < FW * 4 + 40) begin
            @(negedge clk);
            mr = (mode == 0) ? 1'b1 : pat[3 - (cyc % 4)];
            m_ready = mr;
            #1;
            if (held) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, hd);
                held = 1'b0;
            end
            if (m_valid) begin
                if (mr) begin
                    chk("m_data", m_data, 32'hFEA7_0000 + 32'(k));
                    chk("m_last", m_last, (k == FW - 1));
                    k++;
                end else begin
                    held = 1'b1; hd = m_data;
                end
            end
            cyc++;
        end
        chk("drain_words", k, FW);
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("drain_idle", {busy, m_valid}, 2'b00);
    endtask

    initial begin
        set_beat(0, 0, 0, 4'b0001, 0, 3'b000, 0);
        set_beat(1, 0, 0, 4'b0001, 4, 3'b000, 0);
        set_beat(2, 0, 1, 4'b0001, 8, 3'b001, 0);
        set_beat(3, 1, 0, 4'b0010, 0, 3'b001, 0);
        set_beat(4, 1, 1, 4'b0010, 4, 3'b011, 0);
        set_beat(5, 2, 0, 4'b0100, 0, 3'b011, 0);
        set_beat(6, 2, 0, 4'b0100, 4, 3'b011, 0);
        set_beat(7, 2, 0, 4'b0100, 8, 3'b011, 0);
        set_beat(8, 2, 1, 4'b0100, 12, 3'b111, 0);
        set_beat(9, 3, 1, 4'b1000, 0, 3'b111, 0);
        // Weight overflow: depth 4, fifth beat dropped.
        set_beat(10, 0, 1, 4'b0001, 0, 3'b001, 0);
        set_beat(11, 1, 1, 4'b0010, 0, 3'b011, 0);
        set_beat(12, 2, 0, 4'b0100, 0, 3'b011, 0);
        set_beat(13, 2, 0, 4'b0100, 4, 3'b011, 0);
        set_beat(14, 2, 0, 4'b0100, 8, 3'b011, 0);
        set_beat(15, 2, 0, 4'b0100, 12, 3'b011, 0);
        set_beat(16, 2, 1, 4'b0000, 0, 3'b111, 1);
        set_beat(17, 3, 1, 4'b1000, 0, 3'b111, 1);
        // Partial load interrupted by reset in the weight region.
        set_beat(18, 0, 1, 4'b0001, 0, 3'b001, 0);
        set_beat(19, 1, 1, 4'b0010, 0, 3'b011, 0);
        set_beat(20, 2, 0, 4'b0100, 0, 3'b011, 0);
        set_beat(21, 2, 0, 4'b0100, 4, 3'b011, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", {busy, s_ready, m_valid, m_last, err}, 5'b0);
        chk("rst_done", {wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done}, 3'b0);
        chk("rst_ena", {subgraph_bram_ena, wgt_bram_ena, h_node_info_bram_ena, h_data_bram_ena}, 4'b0);
        chk("rst_data", {m_data, 24'(feat_bram_addrb)}, 64'd0);
        @(negedge clk); rst = 1'b0;

        // Full load, gat_ready after 10 cycles, drain with m_ready 1-0-0-1
        pulse_start();
        chk("busy_after_start", busy, 1);
        run_beats(0, 9);
        repeat (10) begin
            @(posedge clk); #1;
            chk("wait_gat", {busy, s_ready, m_valid}, 3'b100);
        end
        @(negedge clk); gat_ready = 1'b1;
        drain(1);
        chk("done_kept", {wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done}, 3'b111);

        // gat_ready already high on WAIT_GAT entry; start ignored in DRAIN
        pulse_start();
        chk("start_clears", {wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done, err}, 4'b0);
        run_beats(0, 8);
        @(negedge clk);
        s_valid = 1'b1; s_data = tbl[9].data; s_last = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        chk("wait_entry", {busy, s_ready, m_valid}, 3'b100);
        @(posedge clk); #1;
        chk("drain_d0", m_valid, 0);
        @(posedge clk); #1;
        chk("drain_d1", m_valid, 0);
        @(posedge clk); #1;
        chk("first_valid", m_valid, 1);
        chk("first_data", m_data, 32'hFEA7_0000);
        pulse_start();
        #1;
        chk("start_in_drain", {busy, s_ready, m_valid}, 3'b101);
        drain(0);

        // Overflow of the weight region
        pulse_start();
        run_beats(10, 17);
        drain(0);
        chk("err_sticky", err, 1);
        pulse_start();
        chk("err_cleared", err, 0);

        // Reset mid weight load, then a clean reload
        run_beats(18, 21);
        @(negedge clk);
        s_valid = 1'b1; s_data = 32'h1234_5678; s_last = 1'b0;
        #1;
        chk("pre_rst_ena", wgt_bram_ena, 1);
        rst = 1'b1;
        #1;
        chk("rst_async", {busy, s_ready, wgt_bram_ena, wgt_bram_wea, err}, 5'b0);
        chk("rst_async_addr", {wgt_bram_din, wgt_bram_addra}, 36'd0);
        chk("rst_async_done", {wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done}, 3'b0);
        @(negedge clk); rst = 1'b0; s_valid = 1'b0;
        pulse_start();
        run_beats(0, 9);
        drain(0);

`ifdef GAT_LOAD_TIMEOUT_EN
        begin
            int n = 0;
            gat_ready = 1'b0;
            pulse_start();
            run_beats(0, 9);
            while (busy && n < 200) begin
                @(posedge clk); #1;
                n++;
                chk("tmo_no_valid", m_valid, 0);
            end
            chk("tmo_cycles", n, 100);
            chk("tmo_err", {busy, err}, 2'b01);
        end
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
